// File: rtl/keypad_scanner.sv
// 5x4 matrix keypad scanner: walks an active-low column, synchronises the rows,
// debounces press and release and reports a held key as keyCode/ready/press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 16,
  parameter int unsigned DEBOUNCE_CNT = 32
) (
  input  logic       clk,
  input  logic       clrn,
  output logic [4:0] key_col,
  input  logic [3:0] key_row,
  output logic [4:0] keyCode,
  output logic       ready,
  output logic       press
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t          r_state;
  logic [2:0]      r_col_idx;
  logic [2:0]      r_cand_col;
  logic [1:0]      r_cand_row;
  logic [DW-1:0]   r_dwell;
  logic [BW-1:0]   r_deb;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [4:0]      r_key_code;
  logic            r_ready;
  logic            r_press;

  logic [2:0]      w_next_col;
  logic [1:0]      w_low_row;
  logic            w_cand_bit;

  assign w_next_col = (r_col_idx == 3'd4) ? 3'd0 : r_col_idx + 3'd1;
  assign w_cand_bit = r_sync2[r_cand_row];

  // Lowest-index low row wins when several rows are pressed in one column.
  always_comb begin
    w_low_row = 2'd0;
    if (!r_sync2[0])      w_low_row = 2'd0;
    else if (!r_sync2[1]) w_low_row = 2'd1;
    else if (!r_sync2[2]) w_low_row = 2'd2;
    else                  w_low_row = 2'd3;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_row;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= SCAN;
      r_col_idx  <= '0;
      r_cand_col <= '0;
      r_cand_row <= '0;
      r_dwell    <= '0;
      r_deb      <= '0;
      r_key_code <= '0;
      r_ready    <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_press <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_dwell == DWELL_LAST) begin
            r_dwell <= '0;
            if (r_sync2 == 4'hF) begin
              r_col_idx <= w_next_col;
            end else begin
              r_cand_row <= w_low_row;
              r_cand_col <= r_col_idx;
              r_deb      <= '0;
              r_state    <= DEBOUNCE;
            end
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!w_cand_bit) begin
            if (r_deb == DEB_LAST) begin
              r_deb      <= '0;
              r_key_code <= {r_cand_col, 2'b00} + {3'b000, r_cand_row};
              r_ready    <= 1'b1;
              r_press    <= 1'b1;
              r_state    <= HELD;
            end else begin
              r_deb <= r_deb + 1'b1;
            end
          end else begin
            r_deb     <= '0;
            r_col_idx <= w_next_col;
            r_state   <= SCAN;
          end
        end
        HELD: begin
          // Column stays frozen here, so other keys are never sampled.
          if (w_cand_bit) begin
            if (r_deb == DEB_LAST) begin
              r_deb     <= '0;
              r_ready   <= 1'b0;
              r_col_idx <= w_next_col;
              r_state   <= SCAN;
            end else begin
              r_deb <= r_deb + 1'b1;
            end
          end else begin
            r_deb <= '0;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign key_col = ~(5'b00001 << r_col_idx);
  assign keyCode = r_key_code;
  assign ready   = r_ready;
  assign press   = r_press;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural 5x4 keypad drives the rows
// from the scanned column, with a manual row override for bounce sequences.
module tb_keypad_scanner;

  logic        clk;
  logic        clrn;
  logic [4:0]  key_col;
  logic [3:0]  key_row;
  logic [4:0]  keyCode;
  logic        ready;
  logic        press;

  logic [19:0] keys;
  logic        manual;
  logic [3:0]  man_row;
  logic [3:0]  model_row;

  int n_cmp;
  int n_fail;
  int press_cnt;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(4)) dut (
    .clk     (clk),
    .clrn    (clrn),
    .key_col (key_col),
    .key_row (key_row),
    .keyCode (keyCode),
    .ready   (ready),
    .press   (press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    model_row = 4'hF;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 4; r++)
        if (!key_col[c] && keys[c*4+r]) model_row[r] = 1'b0;
  end
  assign key_row = manual ? man_row : model_row;

  typedef struct {
    int unsigned cyc;
    logic [19:0] keys;
    logic [4:0]  col;
    logic        rdy;
    logic [4:0]  code;
    logic        prs;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (press) press_cnt++;
    check("press_without_ready", {31'b0, press & ~ready}, 32'd0);
  endtask

  task automatic wait_col(input logic [4:0] target);
    int n;
    n = 0;
    while (key_col == target && n < 40) begin step(); n++; end
    n = 0;
    while (key_col != target && n < 40) begin step(); n++; end
    check("wait_col", {27'b0, key_col}, {27'b0, target});
  endtask

  task automatic wait_ready(input logic lvl);
    int n;
    n = 0;
    while (ready != lvl && n < 80) begin step(); n++; end
    check("wait_ready", {31'b0, ready}, {31'b0, lvl});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_col"},   {27'b0, key_col}, 32'h1E);
    check({tag, "_ready"}, {31'b0, ready},   32'd0);
    check({tag, "_code"},  {27'b0, keyCode}, 32'd0);
    check({tag, "_press"}, {31'b0, press},   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pc0, pc1, pc2;
    n_cmp = 0; n_fail = 0; press_cnt = 0;
    clrn = 1'b0; keys = '0; manual = 1'b0; man_row = 4'hF;

    vecs[0]  = '{0,  20'h00000, 5'b11110, 1'b0, 5'h00, 1'b0};
    vecs[1]  = '{3,  20'h00000, 5'b11110, 1'b0, 5'h00, 1'b0};
    vecs[2]  = '{1,  20'h00000, 5'b11101, 1'b0, 5'h00, 1'b0};
    vecs[3]  = '{3,  20'h00000, 5'b11101, 1'b0, 5'h00, 1'b0};
    vecs[4]  = '{1,  20'h00000, 5'b11011, 1'b0, 5'h00, 1'b0};
    vecs[5]  = '{4,  20'h00000, 5'b10111, 1'b0, 5'h00, 1'b0};
    vecs[6]  = '{4,  20'h00000, 5'b01111, 1'b0, 5'h00, 1'b0};
    vecs[7]  = '{4,  20'h00000, 5'b11110, 1'b0, 5'h00, 1'b0};
    vecs[8]  = '{20, 20'h10000, 5'b01111, 1'b0, 5'h00, 1'b0};
    vecs[9]  = '{3,  20'h10000, 5'b01111, 1'b0, 5'h00, 1'b0};
    vecs[10] = '{1,  20'h10000, 5'b01111, 1'b1, 5'h10, 1'b1};
    vecs[11] = '{1,  20'h10000, 5'b01111, 1'b1, 5'h10, 1'b0};
    vecs[12] = '{30, 20'h10000, 5'b01111, 1'b1, 5'h10, 1'b0};
    vecs[13] = '{5,  20'h00000, 5'b01111, 1'b1, 5'h10, 1'b0};
    vecs[14] = '{1,  20'h00000, 5'b11110, 1'b0, 5'h10, 1'b0};
    vecs[15] = '{4,  20'h00000, 5'b11101, 1'b0, 5'h10, 1'b0};

    step(); step();
    check_reset_vals("reset");
    clrn = 1'b1;

    // Idle scan, then press/hold/release of col4,row0.
    for (int i = 0; i < NV; i++) begin
      keys = vecs[i].keys;
      for (int unsigned k = 0; k < vecs[i].cyc; k++) step();
      check($sformatf("v%0d_col", i),   {27'b0, key_col}, {27'b0, vecs[i].col});
      check($sformatf("v%0d_ready", i), {31'b0, ready},   {31'b0, vecs[i].rdy});
      check($sformatf("v%0d_code", i),  {27'b0, keyCode}, {27'b0, vecs[i].code});
      check($sformatf("v%0d_press", i), {31'b0, press},   {31'b0, vecs[i].prs});
    end

    // Press bounce at col2: low 2, high 1, then held; first attempt aborts.
    wait_col(5'b11011);
    pc0 = press_cnt;
    manual = 1'b1; man_row = 4'hF;
    step(); man_row = 4'b1101;
    step(); step(); man_row = 4'hF;
    step(); manual = 1'b0; keys = 20'h00200;
    step(); step();
    check("bounce_abort_col",   {27'b0, key_col}, 32'h17);
    check("bounce_abort_ready", {31'b0, ready},   32'd0);
    check("bounce_abort_press", press_cnt,        pc0);
    wait_ready(1'b1);
    check("bounce_accept_press", {31'b0, press},   32'd1);
    check("bounce_accept_code",  {27'b0, keyCode}, 32'h09);
    check("bounce_accept_col",   {27'b0, key_col}, 32'h1B);

    // Release bounce in HELD: high 3, low 1, high 4.
    keys = '0;
    step(); step(); step(); keys = 20'h00200;
    step(); keys = '0;
    step(); step(); step(); step(); step();
    check("relbounce_still_held", {31'b0, ready}, 32'd1);
    step();
    check("relbounce_ready", {31'b0, ready},   32'd0);
    check("relbounce_col",   {27'b0, key_col}, 32'h17);
    check("relbounce_code",  {27'b0, keyCode}, 32'h09);
    check("relbounce_npress", press_cnt,        pc0 + 1);

    // Col1 rows 1 and 3 together, then a second key elsewhere while held.
    keys = 20'h000A0;
    wait_ready(1'b1);
    check("multi_code",  {27'b0, keyCode}, 32'h05);
    check("multi_press", {31'b0, press},   32'd1);
    pc1 = press_cnt;
    keys = keys | 20'h01000;
    for (int k = 0; k < 30; k++) step();
    check("rollover_npress", press_cnt,        pc1);
    check("rollover_ready",  {31'b0, ready},   32'd1);
    check("rollover_code",   {27'b0, keyCode}, 32'h05);
    check("rollover_col",    {27'b0, key_col}, 32'h1D);
    keys = '0;
    wait_ready(1'b0);
    check("multi_release_code", {27'b0, keyCode}, 32'h05);

    // Reset during DEBOUNCE of col3,row2.
    keys = 20'h04000;
    wait_col(5'b10111);
    step(); step(); step(); step(); step();
    check("pre_rst_deb_ready", {31'b0, ready}, 32'd0);
    pc2 = press_cnt;
    clrn = 1'b0;
    #1;
    check_reset_vals("rst_deb");
    step(); step();
    check_reset_vals("rst_deb_hold");
    check("rst_deb_npress", press_cnt, pc2);
    clrn = 1'b1;

    // Reset during HELD.
    wait_ready(1'b1);
    check("rehold_code",   {27'b0, keyCode}, 32'h0E);
    check("rehold_npress", press_cnt,        pc2 + 1);
    step(); step(); step();
    clrn = 1'b0;
    #1;
    check_reset_vals("rst_held");
    step();
    clrn = 1'b1;
    step();
    check("post_rst_col",   {27'b0, key_col}, 32'h1E);
    check("post_rst_ready", {31'b0, ready},   32'd0);
    keys = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
